// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two requesters
module alu_share_ctrl #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_c,
    output logic              rsp0_z,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_c,
    output logic              rsp1_z,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_z,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic ptr_q, ptr_d, owner_q, owner_d, z_q, z_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic grant1, accept, rsp_hs;
    // requester 1 wins when it is alone or when the pointer names it
    assign grant1 = req1_valid & (~req0_valid | ptr_q);
    assign accept = req0_ready | req1_ready;
    assign rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept)     state_d = EXEC;
        else if (state_q == EXEC)          state_d = RESP;
        else if (state_q == RESP && rsp_hs) state_d = IDLE;
    end
    always_comb begin
        req0_ready = (state_q == IDLE) & req0_valid & ~grant1;
        req1_ready = (state_q == IDLE) & grant1;
        rsp0_valid = (state_q == RESP) & ~owner_q;
        rsp1_valid = (state_q == RESP) & owner_q;
        busy       = state_q != IDLE;
    end
    always_comb begin
        ptr_d   = accept ? ~grant1 : ptr_q;
        owner_d = accept ? grant1 : owner_q;
        sel_d   = accept ? (grant1 ? req1_sel : req0_sel) : sel_q;
        a_d     = accept ? (grant1 ? req1_a : req0_a) : a_q;
        b_d     = accept ? (grant1 ? req1_b : req0_b) : b_q;
        c_d     = (state_q == EXEC) ? alu_c : c_q;
        z_d     = (state_q == EXEC) ? alu_z : z_q;
    end
    assign alu_sel = sel_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign rsp0_c  = c_q;
    assign rsp0_z  = z_q;
    assign rsp1_c  = c_q;
    assign rsp1_z  = z_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vector table plus multi-cycle sequences, with a reference ALU attached
module tb_alu_share_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
    logic [3:0] req0_sel = 0, req1_sel = 0, alu_sel;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic rsp0_valid, rsp0_ready = 0, rsp0_z, rsp1_valid, rsp1_ready = 0, rsp1_z;
    logic [31:0] rsp0_c, rsp1_c, alu_a, alu_b, alu_c;
    logic alu_z, busy;
    int checks = 0, failures = 0;

    typedef struct {
        logic        who;
        logic [3:0]  sel;
        logic [31:0] a, b, c;
        logic        z;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    // reference ALU: and, or, add, sub, slt, nor; anything else returns 0
    always_comb begin
        case (alu_sel)
            4'b0000: alu_c = alu_a & alu_b;
            4'b0001: alu_c = alu_a | alu_b;
            4'b0010: alu_c = alu_a + alu_b;
            4'b0110: alu_c = alu_a - alu_b;
            4'b0111: alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1100: alu_c = ~(alu_a | alu_b);
            default: alu_c = 32'd0;
        endcase
        alu_z = alu_c == 32'd0;
    end

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_z(rsp1_z),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_z(alu_z), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic who, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_valid = 1; req1_sel = sel; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_sel = sel; req0_a = a; req0_b = b;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        rsp0_ready = 1;
        rsp1_ready = 1;
        drive(v.who, v.sel, v.a, v.b);
        #1;
        chk($sformatf("v%0d_ready", idx), {req1_ready, req0_ready}, v.who ? 2'b10 : 2'b01);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        #1;
        chk($sformatf("v%0d_exec_busy", idx), busy, 1);
        chk($sformatf("v%0d_exec_alu", idx), {alu_sel, alu_a, alu_b}, {v.sel, v.a, v.b});
        chk($sformatf("v%0d_exec_norsp", idx), {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_rsp_valid", idx), {rsp1_valid, rsp0_valid}, v.who ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_rsp_c", idx), v.who ? rsp1_c : rsp0_c, v.c);
        chk($sformatf("v%0d_rsp_z", idx), v.who ? rsp1_z : rsp0_z, v.z);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_idle", idx), {busy, rsp1_valid, rsp0_valid}, 0);
        chk($sformatf("v%0d_alu_held", idx), alu_a, v.a);
    endtask

    initial begin
        int grants[$];
        int gtimes[$];
        vecs[0] = '{1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0};
        vecs[1] = '{1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[4] = '{1'b1, 4'b0001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0};
        vecs[5] = '{1'b0, 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1};

        #1;
        chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 0);
        chk("reset_alu", {alu_sel, alu_a, alu_b}, 0);
        chk("reset_result", {rsp0_c, rsp0_z}, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        chk("idle_no_ready", {req0_ready, req1_ready, busy}, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // both requesters held valid from reset: grants must alternate 0,1,0,1
        do_reset();
        drive(1'b0, 4'b0010, 32'd1, 32'd1);
        drive(1'b1, 4'b0110, 32'd10, 32'd3);
        rsp0_ready = 1;
        rsp1_ready = 1;
        for (int cyc = 0; cyc < 20 && grants.size() < 4; cyc++) begin
            #1;
            if (req0_ready && req1_ready) chk("rr_two_ready", 2'b11, 2'b01);
            if (req0_ready || req1_ready) begin
                grants.push_back(req1_ready ? 1 : 0);
                gtimes.push_back(cyc);
            end
            if (rsp0_valid) chk("rr_rsp0_c", rsp0_c, 32'd2);
            if (rsp1_valid) chk("rr_rsp1_c", rsp1_c, 32'd7);
            @(negedge clk);
        end
        chk("rr_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
        for (int i = 1; i < gtimes.size(); i++) chk($sformatf("rr_gap%0d", i), gtimes[i] - gtimes[i-1], 3);

        // backpressure on rsp0 while requester 1 waits
        do_reset();
        rsp0_ready = 0;
        drive(1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
        drive(1'b1, 4'b0010, 32'd20, 32'd22);
        #1;
        chk("bp_accept", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("bp_exec_no_req1", req1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold%0d", i), {rsp0_valid, rsp1_valid, req1_ready, rsp0_c}, {3'b100, 32'hF000F000});
            @(negedge clk);
        end
        rsp0_ready = 1;
        #1;
        chk("bp_hs_cycle", {rsp0_valid, req1_ready}, 2'b10);
        @(negedge clk);
        #1;
        chk("bp_req1_granted", {rsp0_valid, req1_ready}, 2'b01);
        @(negedge clk);
        req1_valid = 0;
        rsp1_ready = 1;
        @(negedge clk);
        #1;
        chk("bp_rsp1", {rsp1_valid, rsp0_valid, rsp1_c}, {2'b10, 32'd42});

        // operands changed after accept must not affect the result
        @(negedge clk);
        drive(1'b0, 4'b0010, 32'd100, 32'd1);
        @(negedge clk);
        req0_a = 32'd500;
        req0_sel = 4'b0110;
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("late_change_c", {rsp0_valid, rsp0_c}, {1'b1, 32'd101});
        @(negedge clk);

        // reset asserted while a response is pending discards it
        rsp0_ready = 0;
        drive(1'b0, 4'b0010, 32'd8, 32'd8);
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        chk("mid_resp_valid", rsp0_valid, 1);
        rst = 1;
        #1;
        chk("mid_resp_reset", {rsp0_valid, rsp1_valid, busy, alu_a, rsp0_c}, 0);
        @(negedge clk);
        rst = 0;
        rsp0_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("after_reset%0d", i), {rsp0_valid, rsp1_valid, busy}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
